// File: rtl/wave_gen_pkg.sv
// Shared types for the multi-mode waveform generator, plus the elaboration-time
// quarter-sine table entry generator.
package wave_gen_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        Q1   = 3'd1,
        Q2   = 3'd2,
        Q3   = 3'd3,
        Q4   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_TRI = 2'd0,
        MODE_SIN = 2'd1,
        MODE_SQR = 2'd2,
        MODE_SAW = 2'd3
    } mode_t;

    // Entry a of a quarter sine sampled at bin centres, so the table never
    // touches 0 and the mirrored quadrants join without a repeated sample.
    function automatic int sin_lut_entry(input int a, input int aw, input int mw);
        real full;
        real ang;
        full = (2.0 ** mw) - 1.0;
        ang  = 3.14159265358979 / 2.0 * (real'(a) + 0.5) / (2.0 ** aw);
        return $rtoi(full * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/wave_gen_sin_lut.sv
// Combinational quarter-wave sine ROM: 2^AW entries of MW-bit magnitude,
// filled at elaboration and monotonic non-decreasing in addr.
module sin_quarter_lut
    import wave_gen_pkg::*;
#(
    parameter int AW = 8,
    parameter int MW = 8
) (
    input  logic [AW-1:0] addr,
    output logic [MW-1:0] mag
);

    logic [MW-1:0] rom [2**AW];

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        assign rom[i] = MW'(sin_lut_entry(i, AW, MW));
    end

    assign mag = rom[addr];

endmodule

// File: rtl/wave_gen.sv
// Multi-mode periodic waveform generator: prescaled tick, four-quadrant phase FSM,
// mirrored quarter-wave shaping; one registered sample per tick, offset binary.
module wave_gen
    import wave_gen_pkg::*;
#(
    parameter int DW = 9,
    parameter int AW = 8,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          en,
    input  logic [PW-1:0] period_sel,
    input  logic [1:0]    mode,
    output logic [DW-1:0] sample_out,
    output logic          sample_vld,
    output logic [1:0]    quad,
    output logic          cycle_done
);

    localparam int MW = DW - 1;
    localparam logic [DW-1:0] MIDSCALE = {1'b1, {(DW-1){1'b0}}};
    localparam logic [AW-1:0] PMAX = '1;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] cnt;
    logic [AW-1:0] p;
    mode_t         mode_l;
    logic          upd;
    logic          tick;
    logic [AW-1:0] addr;
    logic [MW-1:0] tri_mag;
    logic [MW-1:0] sin_mag;
    logic [MW-1:0] mag;
    logic [DW-1:0] sample_nxt;

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: state_nxt = Q1;
                Q1, Q2, Q3, Q4: begin
                    tick = (cnt >= period_sel);
                    if (tick && p == PMAX) begin
                        case (state)
                            Q1:      state_nxt = Q2;
                            Q2:      state_nxt = Q3;
                            Q3:      state_nxt = Q4;
                            default: state_nxt = Q1;
                        endcase
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_nxt;
    end

    // upd marks that p/state now hold a sample not yet presented on the output.
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt    <= '0;
            p      <= '0;
            mode_l <= MODE_TRI;
            upd    <= 1'b0;
        end else if (state_nxt == IDLE) begin
            cnt <= '0;
            p   <= '0;
            upd <= 1'b0;
        end else if (state == IDLE) begin
            cnt    <= '0;
            p      <= '0;
            upd    <= 1'b1;
            mode_l <= mode_t'(mode);
        end else begin
            upd <= tick;
            if (tick) begin
                cnt <= '0;
                p   <= p + 1'b1;
                if (p == PMAX && state == Q4) mode_l <= mode_t'(mode);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        case (state)
            Q2:      quad = 2'd1;
            Q3:      quad = 2'd2;
            Q4:      quad = 2'd3;
            default: quad = 2'd0;
        endcase
    end

    assign addr = (state == Q2 || state == Q4) ? ~p : p;

    // Left-align by appending zeros then shifting, which also truncates when wider.
    assign tri_mag = MW'({addr, {MW{1'b0}}} >> AW);

    sin_quarter_lut #(
        .AW (AW),
        .MW (MW)
    ) u_lut (
        .addr (addr),
        .mag  (sin_mag)
    );

    always_comb begin
        mag = '1;
        case (mode_l)
            MODE_TRI: mag = tri_mag;
            MODE_SIN: mag = sin_mag;
            default:  mag = '1;
        endcase
    end

    always_comb begin
        sample_nxt = MIDSCALE;
        if (mode_l == MODE_SAW)
            sample_nxt = DW'({quad, p, {DW{1'b0}}} >> (AW + 2));
        else if (state == Q1 || state == Q2)
            sample_nxt = {1'b1, mag};
        else
            sample_nxt = {1'b0, ~mag};
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sample_out <= MIDSCALE;
            sample_vld <= 1'b0;
            cycle_done <= 1'b0;
        end else if (state == IDLE) begin
            sample_out <= MIDSCALE;
            sample_vld <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            sample_out <= sample_nxt;
            sample_vld <= upd;
            cycle_done <= upd && state == Q4 && p == PMAX;
        end
    end

endmodule

// File: tb/tb_wave_gen.sv
// Randomised and directed bench for wave_gen (DW=9, AW=8); expected samples come
// from a per-quadrant arithmetic model of the waveform, indexed by sample count.
module tb_wave_gen;

    localparam int DW = 9;
    localparam int AW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          resetb = 1'b1;
    logic          en = 1'b0;
    logic [PW-1:0] period_sel = '0;
    logic [1:0]    mode = '0;
    logic [DW-1:0] sample_out;
    logic          sample_vld;
    logic [1:0]    quad;
    logic          cycle_done;

    int total = 0;
    int bad   = 0;
    int lut [256];

    wave_gen #(.DW(DW), .AW(AW), .PW(PW)) dut (
        .clk        (clk),
        .resetb     (resetb),
        .en         (en),
        .period_sel (period_sel),
        .mode       (mode),
        .sample_out (sample_out),
        .sample_vld (sample_vld),
        .quad       (quad),
        .cycle_done (cycle_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // Sample k of a continuous run, built from the quadrant and phase within the period.
    function automatic int exp_sample(input int m, input int k);
        int n, q, ph;
        n  = k % 1024;
        q  = n / 256;
        ph = n % 256;
        case (m)
            0: case (q)
                   0: return 256 + ph;
                   1: return 511 - ph;
                   2: return 255 - ph;
                   default: return ph;
               endcase
            1: case (q)
                   0: return 256 + lut[ph];
                   1: return 256 + lut[255 - ph];
                   2: return 255 - lut[ph];
                   default: return 255 - lut[255 - ph];
               endcase
            2: return (q < 2) ? 511 : 0;
            default: return n >> 1;
        endcase
    endfunction

    // Starts from IDLE, runs nsamp samples, switching the mode input to m_b after sample sw_k.
    task automatic run(input int m_a, input int m_b, input int sw_k, input int ps, input int nsamp);
        int k, gap, budget, cur;
        mode       = 2'(m_a);
        period_sel = PW'(ps);
        en         = 1'b1;
        k      = 0;
        gap    = 0;
        budget = nsamp * (ps + 1) + 20;
        while (k < nsamp && budget > 0) begin
            step();
            budget--;
            gap++;
            if (sample_vld) begin
                cur = (k < 1024) ? m_a : m_b;
                chk("sample", 32'(sample_out), 32'(exp_sample(cur, k)));
                chk("vld_gap", 32'(gap), 32'((k == 0) ? 2 : ps + 1));
                chk("cycle_done", 32'(cycle_done), 32'((k % 1024) == 1023));
                if (ps > 0) chk("quad", 32'(quad), 32'((k % 1024) / 256));
                k++;
                gap = 0;
                if (k == sw_k) mode = 2'(m_b);
            end else if (cycle_done) begin
                chk("done_without_vld", 32'(cycle_done), 32'd0);
            end
        end
        if (k < nsamp) chk("run_timeout", 32'(k), 32'(nsamp));
    endtask

    task automatic go_idle();
        en = 1'b0;
        step();
        chk("idle_quad", 32'(quad), 32'd0);
        step();
        chk("idle_sample", 32'(sample_out), 32'd256);
        chk("idle_vld", 32'(sample_vld), 32'd0);
        chk("idle_done", 32'(cycle_done), 32'd0);
    endtask

    task automatic wait_vld(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_vld && n < 20);
    endtask

    initial begin
        int m, ps, n;
        for (int i = 0; i < 256; i++)
            lut[i] = $rtoi(255.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / 256.0) + 0.5);

        #1 resetb = 1'b0;
        #2;
        chk("rst_sample", 32'(sample_out), 32'd256);
        chk("rst_vld", 32'(sample_vld), 32'd0);
        chk("rst_quad", 32'(quad), 32'd0);
        chk("rst_done", 32'(cycle_done), 32'd0);
        repeat (2) @(posedge clk);
        #2 resetb = 1'b1;
        step();
        step();
        chk("post_rst_sample", 32'(sample_out), 32'd256);
        chk("post_rst_vld", 32'(sample_vld), 32'd0);

        run(0, 0, -1, 0, 1030);
        go_idle();
        run(2, 2, -1, 3, 1024);
        go_idle();
        run(1, 1, -1, 0, 1024);
        go_idle();
        run(3, 3, -1, $urandom_range(2, 0), 1030);
        go_idle();

        // Triangle switched to square in mid-Q2; square only from the next Q1.
        run(0, 2, 300, 0, 1280);
        go_idle();

        repeat (2) begin
            m  = $urandom_range(3, 0);
            ps = $urandom_range(3, 0);
            run(m, m, -1, ps, 600);
            go_idle();
        end

        // period_sel shrinks below the running count.
        mode       = 2'd0;
        period_sel = 8'd200;
        en         = 1'b1;
        step();
        repeat (100) step();
        period_sel = 8'd5;
        step();
        step();
        chk("ps_drop_vld", 32'(sample_vld), 32'd1);
        chk("ps_drop_sample", 32'(sample_out), 32'd257);
        wait_vld(n);
        chk("ps_drop_gap1", 32'(n), 32'd6);
        chk("ps_drop_sample2", 32'(sample_out), 32'd258);
        wait_vld(n);
        chk("ps_drop_gap2", 32'(n), 32'd6);
        chk("ps_drop_sample3", 32'(sample_out), 32'd259);
        go_idle();

        // Enable dropped in Q3.
        run(0, 0, -1, 0, 600);
        chk("q3_quad", 32'(quad), 32'd2);
        go_idle();

        // Asynchronous reset in mid-Q1, then a clean sine restart.
        run(1, 1, -1, 2, 20);
        @(posedge clk);
        #3 resetb = 1'b0;
        en = 1'b0;
        #1;
        chk("arst_sample", 32'(sample_out), 32'd256);
        chk("arst_vld", 32'(sample_vld), 32'd0);
        chk("arst_quad", 32'(quad), 32'd0);
        chk("arst_done", 32'(cycle_done), 32'd0);
        #2 resetb = 1'b1;
        step();
        run(1, 1, -1, 2, 10);
        go_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_gen.md
# wave_gen

Parametrised multi-mode periodic waveform generator driving the DAC sample path. It replaces the single-shape triangle generator with a single-clock-domain design: a prescaler produces a clock-enable tick rather than a derived clock. A four-quadrant phase FSM feeds a mirrored quarter-wave address into a shape stage, producing triangle, quarter-wave sine, square or sawtooth in offset binary. Output width and phase resolution are parameters.

## Interface
- DW, 9, output sample width (≥ 3); magnitude width MW = DW-1
- AW, 8, phase bits per quadrant (≥ 2); 2^AW ticks per quadrant
- PW, 8, prescaler / period_sel width (≥ 1)
- clk  in  1  clock
- resetb  in  1  reset, asynchronous, active-low
- en  in  1  run enable; low forces IDLE
- period_sel  in  PW  tick divider; tick rate = clk/(period_sel+1)
- mode  in  2  0 triangle, 1 sine, 2 square, 3 sawtooth
- sample_out  out  DW  offset-binary sample, midscale = 2^(DW-1)
- sample_vld  out  1  one-cycle pulse when sample_out takes a new value
- quad  out  2  current quadrant (0..3); 0 in IDLE
- cycle_done  out  1  one-cycle pulse with the last sample of Q4

## Operation
- FSM states: IDLE, Q1, Q2, Q3, Q4. IDLE→Q1 when en=1. Qn→Qn+1 (Q4→Q1) on a tick with p = 2^AW-1. Any state→IDLE on the clock after en=0.
- Prescaler cnt (PW bits) runs only outside IDLE. Tick when cnt ≥ period_sel, then cnt←0; otherwise cnt+1. If period_sel drops below cnt, the next cycle ticks and wraps. period_sel=0 ticks every cycle.
- Phase p (AW bits) is cleared on IDLE→Q1. On each tick p←p+1, wrapping 2^AW-1→0 coincident with the quadrant change.
- Address: addr = p in Q1/Q3; addr = ~p in Q2/Q4.
- Magnitude mag (MW bits):
  - Triangle: addr left-aligned into MW bits. If AW ≥ MW take the top MW bits; otherwise append zero LSBs.
  - Sine: sin_quarter_lut(addr).
  - Square: all ones.
- Sample:
  - Triangle, sine, square: Q1/Q2 sample = {1, mag}; Q3/Q4 sample = {0, ~mag}.
  - Sawtooth: sample = {quad, p} left-aligned to DW bits (truncate LSBs, or pad zero LSBs).
- mode is latched into mode_l on IDLE→Q1 and on each Q4→Q1 transition. A mid-cycle mode change takes effect at the next cycle boundary.
- IDLE outputs: sample_out = 2^(DW-1), quad = 0, sample_vld = 0, cycle_done = 0. cnt and p are held at 0.
- Reset values:
  - Outputs: sample_out = 2^(DW-1), sample_vld = 0, quad = 0, cycle_done = 0.
  - Internal: FSM = IDLE, cnt = 0, p = 0, mode_l = 0.
- sin_quarter_lut entry a = round((2^MW-1)·sin(π/2·(a+0.5)/2^AW)). Entries are computed at elaboration, monotonic non-decreasing.

## Timing
- en sampled high at edge E0 → Q1 from E0, cnt = 0, p = 0.
- First sample (p=0) is on sample_out from E0+1, with sample_vld high for that one cycle.
- Tick in cycle T → p updates at end of T → sample_out updates at end of T+1 → sample_vld high during T+2.
- Sample latency from phase register to output is 1 clk.
- Full waveform period = 4·2^AW·(period_sel+1) clk.
- cycle_done is aligned with sample_vld of the Q4 p = 2^AW-1 sample.
- en falls at edge Ef:
  - IDLE from Ef+1; sample_out = midscale from Ef+2.
  - A pending sample_vld in flight is suppressed.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronous).

## Structure
- Package wave_gen_pkg holds:
  - state_t enum (IDLE, Q1..Q4, 3 bits);
  - mode_t enum (MODE_TRI = 0, MODE_SIN = 1, MODE_SQR = 2, MODE_SAW = 3);
  - the LUT generator function.
- Sub-module sin_quarter_lut: parameters AW, MW; combinational ROM, input addr, output mag.
- Top contains the prescaler, FSM, phase counter, shape mux and output register.

## Test plan
All scenarios use DW=9, AW=8.
- Triangle, period_sel=0, en high: sample sequence 256,257,…,511 (Q1), 511,…,256 (Q2), 255,…,0 (Q3), 0,…,255 (Q4). cycle_done after 1024 samples; sample_vld every clk.
- Square, period_sel=3: sample_vld every 4 clk; 512 samples at 511 then 512 samples at 0; period 4096 clk.
- Sine, period_sel=0:
  - Q1 p=0 → 256+lut(0) = 257; Q1 p=255 → 511.
  - Q3 p=0 → 255-lut(0) = 254.
  - Waveform odd-symmetric about 255.5.
- Sawtooth: output = {quad, p}>>1, rising 0→511 monotonically over one cycle, then wraps to 0.
- Switch mode tri→sqr in mid-Q2: triangle continues through Q4; the first Q1 sample after wrap is 511.
- Disturbance cases:
  - period_sel 200→5 while cnt=100: tick on next clk, then every 6 clk.
  - en low in Q3: midscale 256 two clks later, quad=0.
  - resetb low mid-Q1: outputs reset asynchronously; restart begins at 257.
